// File: rtl/alu_muldiv_seq_if.sv
// Request/result handshake plus the dedicated add/sub ALU bus of the mul/div sequencer.
// The master side is the CPU datapath, which also owns the combinational ALU.
interface alu_muldiv_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] alu_result;

    modport master (
        output start, op, a, b, alu_result,
        input  busy, done, hi, lo, div_zero, alu_a, alu_b, alu_fun, alu_sign
    );

    modport slave (
        input  start, op, a, b, alu_result,
        output busy, done, hi, lo, div_zero, alu_a, alu_b, alu_fun, alu_sign
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply and restoring divide
// on magnitudes, one external add/sub ALU operation per cycle, sign fix-ups at the end.
module alu_muldiv_seq #(
    parameter logic [5:0] FUN_ADD = 6'b000000,
    parameter logic [5:0] FUN_SUB = 6'b000001
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_muldiv_seq_if.slave   bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_NEG_A  = 4'd1;
    localparam logic [3:0] S_NEG_B  = 4'd2;
    localparam logic [3:0] S_LOOP   = 4'd3;
    localparam logic [3:0] S_FIX_LO = 4'd4;
    localparam logic [3:0] S_FIX_HI = 4'd5;
    localparam logic [3:0] S_FIX_Q  = 4'd6;
    localparam logic [3:0] S_FIX_R  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]  r_state,    w_state_next;
    logic        r_is_div,   w_is_div_next;
    logic        r_neg_a,    w_neg_a_next;
    logic        r_neg_b,    w_neg_b_next;
    logic [31:0] r_m,        w_m_next;
    logic [31:0] r_hi,       w_hi_next;
    logic [31:0] r_lo,       w_lo_next;
    logic [4:0]  r_cnt,      w_cnt_next;
    logic        r_z,        w_z_next;
    logic [31:0] r_res_hi,   w_res_hi_next;
    logic [31:0] r_res_lo,   w_res_lo_next;
    logic        r_div_zero, w_div_zero_next;

    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [5:0]  w_alu_fun;
    logic        w_finish;
    logic [31:0] w_rem_shift;
    logic        w_ge;
    logic        w_carry;
    logic        w_signed;

    // r_m holds the multiplicand or the divisor; r_lo holds the multiplier or the quotient.
    assign w_rem_shift = {r_hi[30:0], r_lo[31]};
    assign w_ge        = r_hi[31] | (w_rem_shift >= r_m);
    assign w_carry     = bus.alu_result < r_hi;
    assign w_signed    = ~bus.op[0];

    always_comb begin
        w_alu_a         = '0;
        w_alu_b         = '0;
        w_alu_fun       = FUN_ADD;
        w_state_next    = r_state;
        w_is_div_next   = r_is_div;
        w_neg_a_next    = r_neg_a;
        w_neg_b_next    = r_neg_b;
        w_m_next        = r_m;
        w_hi_next       = r_hi;
        w_lo_next       = r_lo;
        w_cnt_next      = r_cnt;
        w_z_next        = r_z;
        w_res_hi_next   = r_res_hi;
        w_res_lo_next   = r_res_lo;
        w_div_zero_next = r_div_zero;
        w_finish        = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (bus.start) begin
                    w_is_div_next = bus.op[1];
                    w_neg_a_next  = w_signed & bus.a[31];
                    w_neg_b_next  = w_signed & bus.b[31];
                    w_hi_next     = '0;
                    w_cnt_next    = '0;
                    w_z_next      = 1'b0;
                    if (bus.op[1]) begin
                        w_lo_next = bus.a;
                        w_m_next  = bus.b;
                    end else begin
                        w_m_next  = bus.a;
                        w_lo_next = bus.b;
                    end
                    if (bus.op[1] && (bus.b == 32'd0)) begin
                        w_state_next    = S_DONE;
                        w_res_hi_next   = bus.a;
                        w_res_lo_next   = '1;
                        w_div_zero_next = 1'b1;
                    end else if (w_signed && bus.a[31]) begin
                        w_state_next = S_NEG_A;
                    end else if (w_signed && bus.b[31]) begin
                        w_state_next = S_NEG_B;
                    end else begin
                        w_state_next = S_LOOP;
                    end
                end
            end
            S_NEG_A: begin
                w_alu_fun = FUN_SUB;
                w_alu_b   = r_is_div ? r_lo : r_m;
                if (r_is_div) w_lo_next = bus.alu_result;
                else          w_m_next  = bus.alu_result;
                w_state_next = r_neg_b ? S_NEG_B : S_LOOP;
            end
            S_NEG_B: begin
                w_alu_fun = FUN_SUB;
                w_alu_b   = r_is_div ? r_m : r_lo;
                if (r_is_div) w_m_next  = bus.alu_result;
                else          w_lo_next = bus.alu_result;
                w_state_next = S_LOOP;
            end
            S_LOOP: begin
                w_cnt_next = r_cnt + 5'd1;
                if (r_is_div) begin
                    w_alu_fun = FUN_SUB;
                    w_alu_a   = w_rem_shift;
                    w_alu_b   = r_m;
                    w_hi_next = w_ge ? bus.alu_result : w_rem_shift;
                    w_lo_next = {r_lo[30:0], w_ge};
                end else begin
                    w_alu_a   = r_hi;
                    w_alu_b   = r_lo[0] ? r_m : 32'd0;
                    w_hi_next = {w_carry, bus.alu_result[31:1]};
                    w_lo_next = {bus.alu_result[0], r_lo[31:1]};
                end
                if (r_cnt == 5'd31) begin
                    if (!r_is_div && (r_neg_a ^ r_neg_b)) w_state_next = S_FIX_LO;
                    else if (r_is_div && (r_neg_a ^ r_neg_b)) w_state_next = S_FIX_Q;
                    else if (r_is_div && r_neg_a) w_state_next = S_FIX_R;
                    else w_finish = 1'b1;
                end
            end
            S_FIX_LO: begin
                w_alu_fun    = FUN_SUB;
                w_alu_b      = r_lo;
                w_lo_next    = bus.alu_result;
                w_z_next     = (r_lo == 32'd0);
                w_state_next = S_FIX_HI;
            end
            S_FIX_HI: begin
                // High word of a two's-complement negate: carry in only when the low word was zero.
                w_alu_a   = ~r_hi;
                w_alu_b   = {31'd0, r_z};
                w_hi_next = bus.alu_result;
                w_finish  = 1'b1;
            end
            S_FIX_Q: begin
                w_alu_fun = FUN_SUB;
                w_alu_b   = r_lo;
                w_lo_next = bus.alu_result;
                if (r_neg_a) w_state_next = S_FIX_R;
                else         w_finish = 1'b1;
            end
            S_FIX_R: begin
                w_alu_fun = FUN_SUB;
                w_alu_b   = r_hi;
                w_hi_next = bus.alu_result;
                w_finish  = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_finish) begin
            w_state_next    = S_DONE;
            w_res_hi_next   = w_hi_next;
            w_res_lo_next   = w_lo_next;
            w_div_zero_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_m        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_z        <= 1'b0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_is_div   <= w_is_div_next;
            r_neg_a    <= w_neg_a_next;
            r_neg_b    <= w_neg_b_next;
            r_m        <= w_m_next;
            r_hi       <= w_hi_next;
            r_lo       <= w_lo_next;
            r_cnt      <= w_cnt_next;
            r_z        <= w_z_next;
            r_res_hi   <= w_res_hi_next;
            r_res_lo   <= w_res_lo_next;
            r_div_zero <= w_div_zero_next;
        end
    end

    assign bus.busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.hi       = r_res_hi;
    assign bus.lo       = r_res_lo;
    assign bus.div_zero = r_div_zero;
    assign bus.alu_a    = w_alu_a;
    assign bus.alu_b    = w_alu_b;
    assign bus.alu_fun  = w_alu_fun;
    assign bus.alu_sign = 1'b0;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural add/sub ALU on the bus.
module tb_alu_muldiv_seq;
    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [5:0] fun_at [0:63];

    alu_muldiv_seq_if bus ();

    assign bus.alu_result = (bus.alu_fun == FUN_SUB) ? (bus.alu_a - bus.alu_b)
                                                     : (bus.alu_a + bus.alu_b);

    alu_muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz,
                          input int exp_cyc, input int glitch_cyc);
        int cyc;
        int nbusy;
        logic got;
        cyc   = 0;
        nbusy = 0;
        got   = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc < 64) fun_at[cyc] = bus.alu_fun;
            if (cyc == 1 && exp_cyc != 1) check_eq({name, " busy_c1"}, 64'(bus.busy), 64'd1);
            if (bus.done) got = 1'b1;
            else if (bus.busy) nbusy++;
            if (cyc == glitch_cyc) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.a     = 32'd0;
                bus.b     = 32'd0;
            end else if (cyc == glitch_cyc + 1) begin
                bus.start = 1'b0;
            end
        end
        check_eq({name, " done_seen"}, 64'(got), 64'd1);
        check_eq({name, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check_eq({name, " busy_cycles"}, 64'(nbusy), 64'(exp_cyc - 1));
        check_eq({name, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check_eq({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check_eq({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check_eq({name, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        $display("txn %-10s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d cycle=%0d",
                 name, op, a, b, bus.hi, bus.lo, bus.div_zero, cyc);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check_eq("rst busy", 64'(bus.busy), 64'd0);
        check_eq("rst done", 64'(bus.done), 64'd0);
        check_eq("rst hilo", {bus.hi, bus.lo}, 64'd0);
        check_eq("rst div_zero", 64'(bus.div_zero), 64'd0);
        check_eq("rst alu_fun", 64'(bus.alu_fun), 64'(FUN_ADD));
        check_eq("rst alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        check_eq("rst alu_sign", 64'(bus.alu_sign), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, -1);
        run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 36, -1);
        check_eq("mult fun_c1", 64'(fun_at[1]), 64'(FUN_SUB));
        check_eq("mult fun_c2", 64'(fun_at[2]), 64'(FUN_ADD));
        check_eq("mult fun_c34", 64'(fun_at[34]), 64'(FUN_SUB));
        check_eq("mult fun_c35", 64'(fun_at[35]), 64'(FUN_ADD));
        run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 36, -1);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 36, -1);
        run_op("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1, -1);
        run_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, -1);
        run_op("multu_busy", OP_MULTU, 32'd5, 32'd9, 32'd0, 32'd45, 1'b0, 33, 5);
        run_op("mult_m1m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 35, -1);
        run_op("mult_5m4", OP_MULT, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0, 36, -1);
        run_op("mult_0m5", OP_MULT, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0, 1'b0, 36, -1);
        run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 35, -1);

        // Abort a divide partway through with an asynchronous reset.
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("pre_rst busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst done", 64'(bus.done), 64'd0);
        check_eq("mid_rst hilo", {bus.hi, bus.lo}, 64'd0);
        check_eq("mid_rst alu_fun", 64'(bus.alu_fun), 64'(FUN_ADD));
        $display("txn %-10s reset asserted mid-divide", "rst_abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst busy", 64'(bus.busy), 64'd0);
        run_op("multu_2p16", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 33, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
